// File: rtl/noc_port_arbiter.sv
// Round-robin arbiter and single-entry output register for one router output direction.
// Five sources compete; the winner's packet is registered and handed downstream via valid/ready.
module noc_port_arbiter #(
    parameter int unsigned WIDTH_PACKAGE = 50,
    parameter int unsigned NUM_SRC       = 5,
    parameter int unsigned STALL_MAX     = 255
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_SRC-1:0]                in_valid,
    input  logic [NUM_SRC*WIDTH_PACKAGE-1:0]  in_data,
    output logic [NUM_SRC-1:0]                in_ready,
    output logic                              out_valid,
    output logic [WIDTH_PACKAGE-1:0]          out_data,
    output logic [2:0]                        out_src,
    input  logic                              out_ready,
    output logic                              stall_err
);

    localparam int unsigned PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int unsigned CNT_W = (STALL_MAX >= 256) ? $clog2(STALL_MAX + 1) : 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t               state, state_next;
    logic [PTR_W-1:0]     ptr;
    logic [PTR_W-1:0]     gnt;
    logic [PTR_W-1:0]     gnt_inc;
    logic                 found;
    logic                 drain;
    logic                 can_load;
    logic                 accept;
    logic                 stalled;
    logic [CNT_W-1:0]     stall_cnt;
    logic [WIDTH_PACKAGE-1:0] src_data [NUM_SRC];

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
        assign src_data[g] = in_data[g*WIDTH_PACKAGE +: WIDTH_PACKAGE];
    end

    assign out_valid = (state == FULL);
    assign drain     = out_valid & out_ready;
    assign can_load  = (state == EMPTY) | drain;
    assign stalled   = out_valid & ~out_ready;

    // Search starts at ptr and wraps; the first requester found wins.
    always_comb begin
        int unsigned      sum;
        logic [PTR_W-1:0] idx;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            sum = 32'(ptr) + k;
            if (sum >= NUM_SRC) begin
                sum = sum - NUM_SRC;
            end
            idx = PTR_W'(sum);
            if (!found && in_valid[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
    end

    assign accept  = can_load & found & ~reset;
    assign gnt_inc = (gnt == PTR_W'(NUM_SRC - 1)) ? '0 : gnt + PTR_W'(1);

    always_comb begin
        in_ready = '0;
        if (accept) begin
            in_ready[gnt] = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (accept) state_next = FULL;
            FULL:  if (drain && !accept) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= EMPTY;
            ptr      <= '0;
            out_data <= '0;
            out_src  <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                out_data <= src_data[gnt];
                out_src  <= 3'(gnt);
                ptr      <= gnt_inc;
            end
        end
    end

    // The error fires on the edge that completes the STALL_MAX-th stalled cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            stall_err <= 1'b0;
        end else begin
            if (!out_valid || drain) begin
                stall_cnt <= '0;
            end else if (stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (stalled && (32'(stall_cnt) + 32'd1 >= STALL_MAX)) begin
                stall_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_noc_port_arbiter.sv
// Directed bench for noc_port_arbiter: grant order, hold under backpressure, stall flag, reset.
module tb_noc_port_arbiter;

    localparam int unsigned W = 50;
    localparam int unsigned N = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     in_valid;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic [2:0]       out_src;
    logic             out_ready;
    logic             stall_err;

    logic [W-1:0]     src_pkt [N];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    noc_port_arbiter #(
        .WIDTH_PACKAGE (W),
        .NUM_SRC       (N),
        .STALL_MAX     (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .stall_err (stall_err)
    );

    always #5 clk = ~clk;

    always_comb begin
        in_data = '0;
        for (int i = 0; i < N; i++) begin
            in_data[i*W +: W] = src_pkt[i];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] pkt(input int i);
        return {10'(i + 1), 40'hC0FFEE1234};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < N; i++) src_pkt[i] = pkt(i);
        reset     = 1'b1;
        in_valid  = '0;
        out_ready = 1'b0;
        tick();
        in_valid = 5'b11111;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'h0);
        tick();
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_out_data", 64'(out_data), 64'h0);
        check("rst_out_src", 64'(out_src), 64'h0);
        check("rst_stall_err", 64'(stall_err), 64'h0);
        in_valid = '0;
        reset    = 1'b0;

        // Single request from source 2.
        src_pkt[2] = 50'h1_2345_6789_ABCD;
        in_valid   = 5'b00100;
        out_ready  = 1'b1;
        #1;
        check("single_in_ready", 64'(in_ready), 64'h04);
        tick();
        check("single_out_valid", 64'(out_valid), 64'h1);
        check("single_out_data", 64'(out_data), 64'h1_2345_6789_ABCD);
        check("single_out_src", 64'(out_src), 64'h2);

        // ptr must now be 3: with everyone requesting, source 3 wins.
        in_valid = 5'b11111;
        #1;
        check("ptr3_in_ready", 64'(in_ready), 64'h08);
        tick();
        check("rr_src3", 64'(out_src), 64'h3);
        tick();
        check("rr_src4", 64'(out_src), 64'h4);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("rr_seq_src", 64'(out_src), 64'(k % 5));
            check("rr_seq_valid", 64'(out_valid), 64'h1);
            check("rr_seq_data", 64'(out_data), 64'(src_pkt[k % 5]));
        end

        // Backpressure: held output, no grants, sources 1 and 3 waiting.
        out_ready = 1'b0;
        in_valid  = 5'b01010;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("hold_in_ready", 64'(in_ready), 64'h0);
            tick();
            check("hold_out_data", 64'(out_data), 64'(src_pkt[4]));
            check("hold_out_src", 64'(out_src), 64'h4);
            check("hold_out_valid", 64'(out_valid), 64'h1);
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", 64'(in_ready), 64'h02);
        tick();
        check("release_src1", 64'(out_src), 64'h1);
        check("release_valid", 64'(out_valid), 64'h1);
        in_valid = 5'b01000;
        #1;
        check("release2_in_ready", 64'(in_ready), 64'h08);
        tick();
        check("release_src3", 64'(out_src), 64'h3);
        check("no_stall_err_yet", 64'(stall_err), 64'h0);

        // Wrap: ptr=4, sources 0 and 3 request -> 0 then 3.
        in_valid = 5'b01001;
        #1;
        check("wrap_in_ready0", 64'(in_ready), 64'h01);
        tick();
        check("wrap_src0", 64'(out_src), 64'h0);
        in_valid = 5'b01000;
        #1;
        check("wrap_in_ready3", 64'(in_ready), 64'h08);
        tick();
        check("wrap_src3", 64'(out_src), 64'h3);
        in_valid = '0;

        // Stall error after 8 stalled cycles, sticky until reset.
        out_ready = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check("stall_err_low", 64'(stall_err), 64'h0);
        end
        tick();
        check("stall_err_rise", 64'(stall_err), 64'h1);
        out_ready = 1'b1;
        tick();
        check("stall_drained", 64'(out_valid), 64'h0);
        check("stall_err_sticky", 64'(stall_err), 64'h1);
        tick();
        check("stall_err_sticky2", 64'(stall_err), 64'h1);

        // Reset while FULL and source 4 requesting.
        out_ready = 1'b0;
        in_valid  = 5'b00010;
        tick();
        check("pre_rst_src1", 64'(out_src), 64'h1);
        in_valid = 5'b10000;
        reset    = 1'b1;
        #1;
        check("rst_mid_in_ready", 64'(in_ready), 64'h0);
        tick();
        check("rst_mid_out_valid", 64'(out_valid), 64'h0);
        check("rst_mid_stall_err", 64'(stall_err), 64'h0);
        check("rst_mid_in_ready2", 64'(in_ready), 64'h0);
        reset    = 1'b0;
        in_valid = 5'b11111;
        #1;
        check("rst_ptr0", 64'(in_ready), 64'h01);
        in_valid = 5'b10000;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'h10);
        tick();
        check("post_rst_src4", 64'(out_src), 64'h4);
        check("post_rst_data", 64'(out_data), 64'(src_pkt[4]));
        check("post_rst_valid", 64'(out_valid), 64'h1);
        in_valid = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
